fetch_pc: RTL and testbench

Instruction-fetch front end of the CPU datapath. It holds the program counter, issues one word-addressed read at a time to instruction memory, and presents each returned instruction with its PC to the decode stage over a valid/ready handshake. It accepts branch/jump redirects from execute and discards any in-flight fetch made obsolete by a redirect. It feeds decode, whose constant-driven control inputs (const_low/const_high ties) sit directly downstream.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/fetch_pc_pc_reg.sv | 40 ++++
 rtl/fetch_pc.sv | 99 +++++++++
 tb/tb_fetch_pc.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: fetch FSM encoding and default bus widths.
package cpu_pkg;

    localparam int CPU_ADDR_W = 16;
    localparam int CPU_DATA_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_OUT   = 3'd3,
        ST_DRAIN = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/fetch_pc_pc_reg.sv
// Program counter register: load beats increment, otherwise hold.
module pc_reg
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = CPU_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_pc,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_q;

    // Next PC: redirect target, sequential successor (wraps naturally), or hold.
    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_pc;
        end else if (inc) begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    // PC register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch_pc.sv
// Instruction-fetch front end: one outstanding imem read, valid/ready to decode,
// redirects squash any fetch they make obsolete.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | one cycle after reset, nothing issued
// ST_REQ   | presenting read of pc to instruction memory
// ST_WAIT  | request accepted, awaiting its response
// ST_OUT   | instruction and its pc offered to decode
// ST_DRAIN | accepted request is stale; swallow its response
module fetch_pc
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = CPU_ADDR_W,
    parameter int                DATA_W   = CPU_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [DATA_W-1:0] imem_resp_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc
);

    fetch_state_e      state_d, state_q;
    logic [DATA_W-1:0] instr_d, instr_q;
    logic [ADDR_W-1:0] opc_d, opc_q;
    logic [ADDR_W-1:0] pc;
    logic              pc_inc;

    // Advance only on a completed transfer that is not overridden by a redirect.
    assign pc_inc = (state_q == ST_OUT) && out_ready && !redirect_valid;

    pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (redirect_valid),
        .load_pc (redirect_pc),
        .inc     (pc_inc),
        .pc      (pc)
    );

    // Next-state logic; a redirect outranks every other event in each state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = ST_REQ;
            ST_REQ:   if (imem_req_ready) state_d = redirect_valid ? ST_DRAIN : ST_WAIT;
            ST_WAIT: begin
                if (imem_resp_valid)     state_d = redirect_valid ? ST_REQ : ST_OUT;
                else if (redirect_valid) state_d = ST_DRAIN;
            end
            ST_OUT:   if (redirect_valid || out_ready) state_d = ST_REQ;
            ST_DRAIN: if (imem_resp_valid) state_d = ST_REQ;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Capture the response with the pc that fetched it, unless it is being squashed.
    always_comb begin
        instr_d = instr_q;
        opc_d   = opc_q;
        if ((state_q == ST_WAIT) && imem_resp_valid && !redirect_valid) begin
            instr_d = imem_resp_data;
            opc_d   = pc;
        end
    end

    // FSM and capture registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            instr_q <= '0;
            opc_q   <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            opc_q   <= opc_d;
        end
    end

    assign imem_req_valid = (state_q == ST_REQ);
    assign imem_req_addr  = pc;
    assign out_valid      = (state_q == ST_OUT);
    assign out_instr      = instr_q;
    assign out_pc         = opc_q;

endmodule

// File: tb/tb_fetch_pc.sv
// Directed bench for fetch_pc; a second instance starts at 0xFFFF to see the wrap.
module tb_fetch_pc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_ready, resp_valid, out_ready, redirect_valid;
    logic [15:0] resp_data, redirect_pc;

    logic        a_req_valid, a_out_valid, b_req_valid, b_out_valid;
    logic [15:0] a_req_addr, a_out_instr, a_out_pc;
    logic [15:0] b_req_addr, b_out_instr, b_out_pc;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fetch_pc #(.ADDR_W(16), .DATA_W(16), .RESET_PC(16'h0000)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(a_req_valid), .imem_req_ready(req_ready), .imem_req_addr(a_req_addr),
        .imem_resp_valid(resp_valid), .imem_resp_data(resp_data),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_instr(a_out_instr), .out_pc(a_out_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    fetch_pc #(.ADDR_W(16), .DATA_W(16), .RESET_PC(16'hFFFF)) u_dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(b_req_valid), .imem_req_ready(req_ready), .imem_req_addr(b_req_addr),
        .imem_resp_valid(resp_valid), .imem_resp_data(resp_data),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_instr(b_out_instr), .out_pc(b_out_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_ready = 1'b0; resp_valid = 1'b0; resp_data = '0;
        out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        repeat (3) cyc();
        n_checks++;
        if ({a_req_valid, a_out_valid, a_req_addr, a_out_instr, a_out_pc} !== 50'h0)
            $display("FAIL reset_state: got req_v=%b out_v=%b addr=%h instr=%h pc=%h, expected all zero",
                     a_req_valid, a_out_valid, a_req_addr, a_out_instr, a_out_pc);
        else n_pass++;
        n_checks++;
        if (b_req_addr !== 16'hFFFF)
            $display("FAIL reset_pc_wrap_inst: got %h expected ffff", b_req_addr);
        else n_pass++;
        rst_n = 1'b1;
        n_checks++;
        if (a_req_valid !== 1'b0)
            $display("FAIL first_cycle_no_req: got %b expected 0", a_req_valid);
        else n_pass++;
        cyc();
        n_checks++;
        if ({a_req_valid, a_req_addr} !== {1'b1, 16'h0000})
            $display("FAIL second_cycle_req: got v=%b addr=%h expected v=1 addr=0000", a_req_valid, a_req_addr);
        else n_pass++;
    endtask

    task automatic test_stream_and_wrap();
        logic [15:0] exp_a_pc [4] = '{16'h0000, 16'h0001, 16'h0002, 16'h0003};
        logic [15:0] exp_b_pc [4] = '{16'hFFFF, 16'h0000, 16'h0001, 16'h0002};
        logic [15:0] exp_data [4] = '{16'hA5A5, 16'hA5A4, 16'hA5A7, 16'hA5A6};
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({a_req_valid, a_req_addr} !== {1'b1, exp_a_pc[i]})
                $display("FAIL stream_req[%0d]: got v=%b addr=%h expected v=1 addr=%h", i, a_req_valid, a_req_addr, exp_a_pc[i]);
            else n_pass++;
            req_ready = 1'b1;
            cyc();
            req_ready = 1'b0;
            resp_valid = 1'b1;
            resp_data = exp_data[i];
            cyc();
            resp_valid = 1'b0;
            n_checks++;
            if ({a_out_valid, a_out_pc, a_out_instr} !== {1'b1, exp_a_pc[i], exp_data[i]})
                $display("FAIL stream_out[%0d]: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h",
                         i, a_out_valid, a_out_pc, a_out_instr, exp_a_pc[i], exp_data[i]);
            else n_pass++;
            n_checks++;
            if ({b_out_valid, b_out_pc} !== {1'b1, exp_b_pc[i]})
                $display("FAIL wrap_out_pc[%0d]: got v=%b pc=%h expected v=1 pc=%h", i, b_out_valid, b_out_pc, exp_b_pc[i]);
            else n_pass++;
            out_ready = 1'b1;
            cyc();
            out_ready = 1'b0;
        end
        n_checks++;
        if (a_req_addr !== 16'h0004)
            $display("FAIL stream_next_addr: got %h expected 0004", a_req_addr);
        else n_pass++;
    endtask

    task automatic test_stall();
        req_ready = 1'b1;
        cyc();
        req_ready = 1'b0;
        resp_valid = 1'b1;
        resp_data = 16'hBEEF;
        cyc();
        resp_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if ({a_out_valid, a_out_instr, a_out_pc, a_req_valid, a_req_addr} !== {1'b1, 16'hBEEF, 16'h0004, 1'b0, 16'h0004})
                $display("FAIL stall_hold[%0d]: got v=%b instr=%h pc=%h req_v=%b addr=%h expected 1 beef 0004 0 0004",
                         k, a_out_valid, a_out_instr, a_out_pc, a_req_valid, a_req_addr);
            else n_pass++;
            cyc();
        end
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        n_checks++;
        if ({a_out_valid, a_req_valid, a_req_addr} !== {1'b0, 1'b1, 16'h0005})
            $display("FAIL stall_release: got out_v=%b req_v=%b addr=%h expected 0 1 0005", a_out_valid, a_req_valid, a_req_addr);
        else n_pass++;
    endtask

    task automatic test_redirect_wait();
        req_ready = 1'b1;
        cyc();
        req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 16'h0040;
        cyc();
        redirect_valid = 1'b0;
        n_checks++;
        if ({a_req_valid, a_out_valid, a_req_addr} !== {1'b0, 1'b0, 16'h0040})
            $display("FAIL redir_wait_drain: got req_v=%b out_v=%b addr=%h expected 0 0 0040", a_req_valid, a_out_valid, a_req_addr);
        else n_pass++;
        cyc();
        cyc();
        n_checks++;
        if ({a_req_valid, a_out_valid} !== 2'b00)
            $display("FAIL redir_wait_still_drain: got req_v=%b out_v=%b expected 0 0", a_req_valid, a_out_valid);
        else n_pass++;
        resp_valid = 1'b1;
        resp_data = 16'hDEAD;
        cyc();
        resp_valid = 1'b0;
        n_checks++;
        if ({a_out_valid, a_req_valid, a_req_addr} !== {1'b0, 1'b1, 16'h0040})
            $display("FAIL redir_wait_discard: got out_v=%b req_v=%b addr=%h expected 0 1 0040", a_out_valid, a_req_valid, a_req_addr);
        else n_pass++;
        req_ready = 1'b1;
        cyc();
        req_ready = 1'b0;
        resp_valid = 1'b1;
        resp_data = 16'h1234;
        cyc();
        resp_valid = 1'b0;
        n_checks++;
        if ({a_out_valid, a_out_pc, a_out_instr} !== {1'b1, 16'h0040, 16'h1234})
            $display("FAIL redir_target_fetch: got v=%b pc=%h instr=%h expected 1 0040 1234", a_out_valid, a_out_pc, a_out_instr);
        else n_pass++;
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
    endtask

    task automatic test_redirect_coincident();
        n_checks++;
        if ({a_req_valid, a_req_addr} !== {1'b1, 16'h0041})
            $display("FAIL coinc_start: got v=%b addr=%h expected 1 0041", a_req_valid, a_req_addr);
        else n_pass++;
        req_ready = 1'b1;
        cyc();
        req_ready = 1'b0;
        resp_valid = 1'b1;
        resp_data = 16'h5555;
        redirect_valid = 1'b1;
        redirect_pc = 16'h0100;
        cyc();
        resp_valid = 1'b0;
        redirect_valid = 1'b0;
        n_checks++;
        if ({a_out_valid, a_req_valid, a_req_addr} !== {1'b0, 1'b1, 16'h0100})
            $display("FAIL coinc_resp_drop: got out_v=%b req_v=%b addr=%h expected 0 1 0100", a_out_valid, a_req_valid, a_req_addr);
        else n_pass++;
        req_ready = 1'b1;
        cyc();
        req_ready = 1'b0;
        resp_valid = 1'b1;
        resp_data = 16'h7777;
        cyc();
        resp_valid = 1'b0;
        n_checks++;
        if ({a_out_valid, a_out_pc, a_out_instr} !== {1'b1, 16'h0100, 16'h7777})
            $display("FAIL coinc_fetch_out: got v=%b pc=%h instr=%h expected 1 0100 7777", a_out_valid, a_out_pc, a_out_instr);
        else n_pass++;
        out_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 16'h0200;
        cyc();
        out_ready = 1'b0;
        redirect_valid = 1'b0;
        n_checks++;
        if ({a_out_valid, a_req_valid, a_req_addr} !== {1'b0, 1'b1, 16'h0200})
            $display("FAIL coinc_out_redirect: got out_v=%b req_v=%b addr=%h expected 0 1 0200", a_out_valid, a_req_valid, a_req_addr);
        else n_pass++;
    endtask

    task automatic test_reset_in_drain();
        req_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 16'h0300;
        cyc();
        req_ready = 1'b0;
        redirect_valid = 1'b0;
        n_checks++;
        if ({a_req_valid, a_out_valid, a_req_addr} !== {1'b0, 1'b0, 16'h0300})
            $display("FAIL req_redirect_drain: got req_v=%b out_v=%b addr=%h expected 0 0 0300", a_req_valid, a_out_valid, a_req_addr);
        else n_pass++;
        rst_n = 1'b0;
        cyc();
        n_checks++;
        if ({a_req_valid, a_out_valid, a_req_addr, a_out_instr, a_out_pc} !== 50'h0)
            $display("FAIL drain_reset: got req_v=%b out_v=%b addr=%h instr=%h pc=%h expected all zero",
                     a_req_valid, a_out_valid, a_req_addr, a_out_instr, a_out_pc);
        else n_pass++;
        rst_n = 1'b1;
        resp_valid = 1'b1;
        resp_data = 16'h9999;
        cyc();
        n_checks++;
        if ({a_req_valid, a_out_valid, a_req_addr} !== {1'b1, 1'b0, 16'h0000})
            $display("FAIL late_resp_idle: got req_v=%b out_v=%b addr=%h expected 1 0 0000", a_req_valid, a_out_valid, a_req_addr);
        else n_pass++;
        cyc();
        resp_valid = 1'b0;
        n_checks++;
        if ({a_req_valid, a_out_valid} !== 2'b10)
            $display("FAIL late_resp_req: got req_v=%b out_v=%b expected 1 0", a_req_valid, a_out_valid);
        else n_pass++;
        req_ready = 1'b1;
        cyc();
        req_ready = 1'b0;
        resp_valid = 1'b1;
        resp_data = 16'h0ABC;
        cyc();
        resp_valid = 1'b0;
        n_checks++;
        if ({a_out_valid, a_out_pc, a_out_instr} !== {1'b1, 16'h0000, 16'h0ABC})
            $display("FAIL post_reset_fetch: got v=%b pc=%h instr=%h expected 1 0000 0abc", a_out_valid, a_out_pc, a_out_instr);
        else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream_and_wrap();
        test_stall();
        test_redirect_wait();
        test_redirect_coincident();
        test_reset_in_drain();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
